// File: rtl/digitizer_buffer_controller_pkg.sv
// Shared state encoding and sizing helper for the
// digitizer sample buffer capture controller.
package digitizer_buffer_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRETRIG,
    ST_ARMED,
    ST_POSTTRIG,
    ST_RD_WAIT,
    ST_RD_VALID,
    ST_FLUSH,
    ST_DONE
  } dbc_state_t;

  function automatic int bit_index(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if (((n >> i) & 1) != 0) r = i;
    return r;
  endfunction

endpackage

// File: rtl/digitizer_buffer_controller_timer.sv
// Loadable down-counter that paces the wait between
// a buffer read pulse and the next valid sample.
module digitizer_latency_timer #(
  parameter int WIDTH = 2
)(
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_rst)
      r_count <= '0;
    else if (i_load)
      r_count <= i_value;
    else if (r_count != '0)
      r_count <= r_count - 1'b1;
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/digitizer_buffer_controller.sv
// Sequences one capture of the digitizer circular buffer:
// pre-fill, armed window, post-fill, paced readout, flush.
module digitizer_buffer_controller
  import digitizer_buffer_controller_pkg::*;
#(
  parameter int BUFFER_SIZE  = 512,
  parameter int READ_LATENCY = 3,
  localparam int CW = bit_index(BUFFER_SIZE) + 1
)(
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CAPTURE_START,
  input  logic          CAPTURE_ABORT,
  input  logic          SAMPLE_TRIG,
  input  logic          TRIGGER_EVENT,
  input  logic [CW-1:0] PRETRIG_COUNT,
  input  logic [CW-1:0] POSTTRIG_COUNT,
  output logic          BUFFER_ENABLE,
  output logic          BUFFER_PRETRIG,
  output logic          BUFFER_TRIGGED,
  output logic          BUFFER_READ,
  input  logic          READ_NEXT,
  output logic          READ_VALID,
  output logic          READ_LAST,
  output logic          CAPTURE_BUSY,
  output logic          CAPTURE_DONE
);

  localparam int LW = bit_index(READ_LATENCY) + 1;
  localparam logic [CW-1:0] C_SIZE = CW'(BUFFER_SIZE);
  localparam logic [CW-1:0] C_MAXP = CW'(BUFFER_SIZE - 1);
  localparam logic [LW-1:0] C_LAT  = LW'(READ_LATENCY);

  dbc_state_t r_state;
  dbc_state_t w_nstate;

  logic [CW-1:0] r_p, r_q, r_t;
  logic [CW-1:0] r_cnt, r_rdcnt, r_diff;
  logic [CW-1:0] w_p, w_q, w_room;
  logic [CW-1:0] w_cnt_inc, w_rdcnt_next, w_diff_next;
  logic r_enable, r_pretrig, r_trigged, r_read;
  logic r_valid, r_last, r_busy, r_done;
  logic w_wr, w_fill, w_abort, w_pop, w_start;
  logic w_tmr_load, w_tmr_zero;

  always_comb begin
    w_p = PRETRIG_COUNT;
    if (PRETRIG_COUNT == '0)
      w_p = CW'(1);
    else if (PRETRIG_COUNT > C_MAXP)
      w_p = C_MAXP;
    w_room = C_SIZE - w_p;
    w_q = (POSTTRIG_COUNT > w_room) ? w_room : POSTTRIG_COUNT;
  end

  assign w_wr   = SAMPLE_TRIG & r_enable;
  assign w_fill = (r_state == ST_PRETRIG) ||
                  (r_state == ST_POSTTRIG);
  assign w_abort = CAPTURE_ABORT &&
                   (r_state inside {ST_PRETRIG, ST_ARMED,
                    ST_POSTTRIG, ST_RD_WAIT, ST_RD_VALID});
  assign w_start = (r_state == ST_IDLE) &&
                   CAPTURE_START && !CAPTURE_ABORT;
  assign w_pop = (r_state == ST_RD_VALID) &&
                 READ_NEXT && !CAPTURE_ABORT;

  assign w_cnt_inc    = r_cnt + 1'b1;
  assign w_rdcnt_next = r_rdcnt + CW'(w_pop);
  // diff is head minus tail; ARMED moves both so it holds
  assign w_diff_next  = r_diff + CW'(w_wr && w_fill)
                      - CW'(r_read);

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      ST_IDLE:
        if (w_start) w_nstate = ST_PRETRIG;
      ST_PRETRIG:
        if (w_wr && w_cnt_inc == r_p)
          w_nstate = ST_ARMED;
      ST_ARMED:
        if (w_wr && TRIGGER_EVENT)
          w_nstate = (r_q == '0) ? ST_RD_WAIT : ST_POSTTRIG;
      ST_POSTTRIG:
        if (w_wr && w_cnt_inc == r_q)
          w_nstate = ST_RD_WAIT;
      ST_RD_WAIT:
        if (w_tmr_zero) w_nstate = ST_RD_VALID;
      ST_RD_VALID:
        if (w_pop)
          w_nstate = (w_rdcnt_next == r_t) ? ST_DONE
                                           : ST_RD_WAIT;
      ST_FLUSH:
        if (w_diff_next == '0) w_nstate = ST_DONE;
      ST_DONE:
        w_nstate = ST_IDLE;
      default:
        w_nstate = ST_IDLE;
    endcase
    if (w_abort) w_nstate = ST_FLUSH;
  end

  assign w_tmr_load = (w_nstate == ST_RD_WAIT) &&
                      (r_state != ST_RD_WAIT);

  digitizer_latency_timer #(
    .WIDTH (LW)
  ) u_timer (
    .clk     (CLK),
    .i_rst   (RESET),
    .i_load  (w_tmr_load),
    .i_value (C_LAT),
    .o_zero  (w_tmr_zero)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_p       <= '0;
      r_q       <= '0;
      r_t       <= '0;
      r_cnt     <= '0;
      r_rdcnt   <= '0;
      r_diff    <= '0;
      r_enable  <= 1'b0;
      r_pretrig <= 1'b0;
      r_trigged <= 1'b0;
      r_read    <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_diff    <= w_diff_next;
      r_rdcnt   <= w_rdcnt_next;
      r_enable  <= w_nstate inside
                   {ST_PRETRIG, ST_ARMED, ST_POSTTRIG};
      r_pretrig <= (w_nstate == ST_PRETRIG);
      r_trigged <= (w_nstate == ST_POSTTRIG);
      r_read    <= w_pop || ((w_nstate == ST_FLUSH) &&
                             (w_diff_next != '0));
      r_valid   <= (w_nstate == ST_RD_VALID);
      r_last    <= (w_nstate == ST_RD_VALID) &&
                   (w_rdcnt_next == r_t - 1'b1);
      r_busy    <= (w_nstate != ST_IDLE);
      r_done    <= (w_nstate == ST_DONE);
      if (r_state == ST_ARMED)
        r_cnt <= '0;
      else if (w_wr && w_fill)
        r_cnt <= w_cnt_inc;
      if (w_start) begin
        r_p     <= w_p;
        r_q     <= w_q;
        r_t     <= w_p + w_q;
        r_cnt   <= '0;
        r_rdcnt <= '0;
      end
    end
  end

  assign BUFFER_ENABLE  = r_enable;
  assign BUFFER_PRETRIG = r_pretrig;
  assign BUFFER_TRIGGED = r_trigged;
  assign BUFFER_READ    = r_read;
  assign READ_VALID     = r_valid;
  assign READ_LAST      = r_last;
  assign CAPTURE_BUSY   = r_busy;
  assign CAPTURE_DONE   = r_done;

endmodule

// File: tb/tb_digitizer_buffer_controller.sv
// Bench pairing the controller with a 16-deep circular
// sample buffer model and a readout scoreboard.
module tb_digitizer_buffer_controller;

  localparam int BS = 16;
  localparam int RL = 3;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET, CAPTURE_START, CAPTURE_ABORT;
  logic       SAMPLE_TRIG, TRIGGER_EVENT, READ_NEXT;
  logic [4:0] PRETRIG_COUNT, POSTTRIG_COUNT;
  logic       BUFFER_ENABLE, BUFFER_PRETRIG, BUFFER_TRIGGED;
  logic       BUFFER_READ, READ_VALID, READ_LAST;
  logic       CAPTURE_BUSY, CAPTURE_DONE;

  logic [7:0] SAMPLE_DATA, BUFFER_DATA;
  logic [7:0] mem [BS];
  logic [3:0] b_head, b_tail;
  int         rd_pulses = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  exp_t       exp_q[$];

  always #5 CLK = ~CLK;

  digitizer_buffer_controller #(
    .BUFFER_SIZE  (BS),
    .READ_LATENCY (RL)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .CAPTURE_START  (CAPTURE_START),
    .CAPTURE_ABORT  (CAPTURE_ABORT),
    .SAMPLE_TRIG    (SAMPLE_TRIG),
    .TRIGGER_EVENT  (TRIGGER_EVENT),
    .PRETRIG_COUNT  (PRETRIG_COUNT),
    .POSTTRIG_COUNT (POSTTRIG_COUNT),
    .BUFFER_ENABLE  (BUFFER_ENABLE),
    .BUFFER_PRETRIG (BUFFER_PRETRIG),
    .BUFFER_TRIGGED (BUFFER_TRIGGED),
    .BUFFER_READ    (BUFFER_READ),
    .READ_NEXT      (READ_NEXT),
    .READ_VALID     (READ_VALID),
    .READ_LAST      (READ_LAST),
    .CAPTURE_BUSY   (CAPTURE_BUSY),
    .CAPTURE_DONE   (CAPTURE_DONE)
  );

  // circular buffer: armed writes slide the tail with the head
  always @(posedge CLK) begin
    if (RESET) begin
      b_head <= '0;
      b_tail <= '0;
    end else begin
      if (SAMPLE_TRIG && BUFFER_ENABLE) begin
        mem[b_head] <= SAMPLE_DATA;
        b_head <= b_head + 4'd1;
      end
      b_tail <= b_tail
        + 4'(SAMPLE_TRIG && BUFFER_ENABLE &&
             !BUFFER_PRETRIG && !BUFFER_TRIGGED)
        + 4'(BUFFER_READ);
    end
    BUFFER_DATA <= mem[b_tail];
    if (BUFFER_READ) rd_pulses <= rd_pulses + 1;
  end

  task automatic start(input int p, input int q);
    @(negedge CLK);
    PRETRIG_COUNT = 5'(p);
    POSTTRIG_COUNT = 5'(q);
    CAPTURE_START = 1'b1;
    @(negedge CLK);
    CAPTURE_START = 1'b0;
  endtask

  task automatic feed(input int base, input int n,
                      input int trig, input bit every);
    for (int i = 0; i < n; i++) begin
      SAMPLE_TRIG = 1'b1;
      SAMPLE_DATA = 8'(base + i);
      TRIGGER_EVENT = (i == trig);
      @(negedge CLK);
      SAMPLE_TRIG = 1'b0;
      TRIGGER_EVENT = 1'b0;
      if (!every) @(negedge CLK);
    end
  endtask

  task automatic push_expect(input int base, input int t,
                             input int p, input int q);
    for (int i = t - p + 1; i <= t + q; i++)
      exp_q.push_back('{d: 8'(base + i), l: (i == t + q)});
  endtask

  task automatic pulse_abort();
    CAPTURE_ABORT = 1'b1;
    @(negedge CLK);
    CAPTURE_ABORT = 1'b0;
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (CAPTURE_DONE) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // scoreboard consumer: pops expected samples as the DUT presents them
  task automatic drain(input bit hold, input bit want_done,
                       input int max_pops);
    int cyc, last_rd, pops;
    bit got;
    exp_t e;
    cyc = 0;
    last_rd = -1;
    pops = 0;
    READ_NEXT = hold;
    while (pops < max_pops && cyc < 400) begin
      @(negedge CLK);
      cyc++;
      if (hold && BUFFER_READ) begin
        if (last_rd >= 0) begin
          n_checks++;
          if (cyc - last_rd !== RL + 2) begin
            n_fail++;
            $display("FAIL read_period: got %0d cycles, want %0d",
                     cyc - last_rd, RL + 2);
          end
        end
        last_rd = cyc;
      end
      if (READ_VALID) begin
        e = exp_q.pop_front();
        pops++;
        n_checks += 2;
        if (BUFFER_DATA !== e.d) begin
          n_fail++;
          $display("FAIL read_data[%0d]: got %0d, want %0d",
                   pops, BUFFER_DATA, e.d);
        end
        if (READ_LAST !== e.l) begin
          n_fail++;
          $display("FAIL read_last[%0d]: got %b, want %b",
                   pops, READ_LAST, e.l);
        end
        READ_NEXT = 1'b1;
      end else if (!hold) begin
        READ_NEXT = 1'b0;
      end
    end
    n_checks++;
    if (pops != max_pops) begin
      n_fail++;
      $display("FAIL read_timeout: got %0d pops, want %0d",
               pops, max_pops);
    end
    if (want_done) begin
      wait_done(got);
      READ_NEXT = 1'b0;
      n_checks++;
      if (!got) begin
        n_fail++;
        $display("FAIL done_pulse: got none, want one");
      end
      @(negedge CLK);
      n_checks++;
      if (b_head !== b_tail || CAPTURE_BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL end_state: head %0d tail %0d busy %b, want equal/0",
                 b_head, b_tail, CAPTURE_BUSY);
      end
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    outs = {BUFFER_ENABLE, BUFFER_PRETRIG, BUFFER_TRIGGED,
            BUFFER_READ, READ_VALID, READ_LAST,
            CAPTURE_BUSY, CAPTURE_DONE};
    n_checks++;
    if (outs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, want 00000000", outs);
    end
    RESET = 1'b0;
    @(negedge CLK);
    CAPTURE_ABORT = 1'b1;
    start(4, 3);
    CAPTURE_ABORT = 1'b0;
    n_checks++;
    if (CAPTURE_BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL start_with_abort: busy %b, want 0", CAPTURE_BUSY);
    end
  endtask

  task automatic test_capture();
    start(4, 3);
    n_checks++;
    if (BUFFER_PRETRIG !== 1'b1 || BUFFER_ENABLE !== 1'b1) begin
      n_fail++;
      $display("FAIL pretrig_flags: pre %b en %b, want 1 1",
               BUFFER_PRETRIG, BUFFER_ENABLE);
    end
    push_expect(0, 6, 4, 3);
    feed(0, 10, 6, 0);
    n_checks++;
    if (BUFFER_ENABLE !== 1'b0 || CAPTURE_BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL after_post: en %b busy %b, want 0 1",
               BUFFER_ENABLE, CAPTURE_BUSY);
    end
    drain(0, 1, 7);
  endtask

  task automatic test_full_buffer();
    start(0, 20);
    push_expect(100, 3, 1, 15);
    feed(100, 19, 3, 0);
    drain(0, 1, 16);
  endtask

  task automatic test_back_to_back();
    start(3, 2);
    push_expect(20, 3, 3, 2);
    feed(20, 6, 3, 1);
    drain(1, 1, 5);
  endtask

  task automatic test_trigger_qualify();
    start(4, 3);
    feed(30, 4, -1, 1);
    n_checks++;
    if (BUFFER_ENABLE !== 1'b1 || BUFFER_PRETRIG !== 1'b0) begin
      n_fail++;
      $display("FAIL armed_flags: en %b pre %b, want 1 0",
               BUFFER_ENABLE, BUFFER_PRETRIG);
    end
    TRIGGER_EVENT = 1'b1;
    @(negedge CLK);
    TRIGGER_EVENT = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (BUFFER_TRIGGED !== 1'b0 || BUFFER_ENABLE !== 1'b1) begin
      n_fail++;
      $display("FAIL unqualified_trig: trig %b en %b, want 0 1",
               BUFFER_TRIGGED, BUFFER_ENABLE);
    end
    push_expect(30, 7, 4, 3);
    feed(34, 7, 3, 1);
    drain(0, 1, 7);
  endtask

  task automatic test_abort();
    int snap;
    bit got;
    snap = rd_pulses;
    start(5, 3);
    feed(40, 7, -1, 0);
    pulse_abort();
    wait_done(got);
    n_checks++;
    if (!got || rd_pulses - snap !== 5 || b_head !== b_tail) begin
      n_fail++;
      $display("FAIL abort_armed: done %b reads %0d ht %0d/%0d, want 1 5 eq",
               got, rd_pulses - snap, b_head, b_tail);
    end
    start(2, 3);
    push_expect(60, 2, 2, 3);
    feed(60, 6, 2, 0);
    drain(0, 1, 5);

    snap = rd_pulses;
    start(3, 6);
    feed(70, 7, 4, 0);
    n_checks++;
    if (BUFFER_TRIGGED !== 1'b1) begin
      n_fail++;
      $display("FAIL posttrig_flag: got %b, want 1", BUFFER_TRIGGED);
    end
    pulse_abort();
    wait_done(got);
    n_checks++;
    if (!got || rd_pulses - snap !== 5 || b_head !== b_tail) begin
      n_fail++;
      $display("FAIL abort_post: done %b reads %0d ht %0d/%0d, want 1 5 eq",
               got, rd_pulses - snap, b_head, b_tail);
    end

    snap = rd_pulses;
    start(4, 3);
    push_expect(90, 6, 4, 3);
    feed(90, 10, 6, 0);
    drain(0, 0, 3);
    CAPTURE_ABORT = 1'b1;
    @(negedge CLK);
    CAPTURE_ABORT = 1'b0;
    READ_NEXT = 1'b0;
    exp_q.delete();
    n_checks++;
    if (READ_VALID !== 1'b0 || BUFFER_READ !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_read_flags: valid %b read %b, want 0 1",
               READ_VALID, BUFFER_READ);
    end
    wait_done(got);
    n_checks++;
    if (!got || rd_pulses - snap !== 7 || b_head !== b_tail) begin
      n_fail++;
      $display("FAIL abort_readout: done %b reads %0d ht %0d/%0d, want 1 7 eq",
               got, rd_pulses - snap, b_head, b_tail);
    end
  endtask

  task automatic test_reset_midcapture();
    logic [7:0] outs;
    start(3, 5);
    feed(50, 6, 4, 0);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    outs = {BUFFER_ENABLE, BUFFER_PRETRIG, BUFFER_TRIGGED,
            BUFFER_READ, READ_VALID, READ_LAST,
            CAPTURE_BUSY, CAPTURE_DONE};
    n_checks++;
    if (outs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: got %b, want 00000000", outs);
    end
    start(2, 2);
    push_expect(80, 2, 2, 2);
    feed(80, 5, 2, 0);
    drain(0, 1, 4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    CAPTURE_START = 1'b0;
    CAPTURE_ABORT = 1'b0;
    SAMPLE_TRIG = 1'b0;
    TRIGGER_EVENT = 1'b0;
    READ_NEXT = 1'b0;
    SAMPLE_DATA = '0;
    PRETRIG_COUNT = '0;
    POSTTRIG_COUNT = '0;
    test_reset();
    test_capture();
    test_full_buffer();
    test_back_to_back();
    test_trigger_qualify();
    test_abort();
    test_reset_midcapture();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
